// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory and buffers
// fetched words in a small prefetch FIFO with a valid/ready output.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    localparam int          PW    = $clog2(DEPTH);
    localparam int          CW    = PW + 1;
    localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) << 2;

    typedef enum logic {RUN, FAULT} state_t;

    state_t        state, state_n;
    logic [31:0]   pc, pc_n, pc_inc, fpc_n;
    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [PW-1:0] rptr, wptr, rptr_n, wptr_n;
    logic [CW-1:0] count, count_n, kept;
    logic          flush, pop, push, redir_ok;
    logic [31:0]   head_instr, head_pc;

    assign pc_inc      = pc + 32'd4;
    assign redir_ok    = (redirect_pc[1:0] == 2'b00) &&
                         ({1'b0, redirect_pc} < LIMIT);
    assign imem_addr   = pc;
    assign out_valid   = (count != '0);
    assign fetch_fault = (state == FAULT);

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        fpc_n      = fault_pc;
        flush      = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        head_instr = imem_rdata;
        head_pc    = pc;
        if (redirect_valid) begin
            flush = 1'b1;
            if (redir_ok) begin
                state_n = RUN;
                pc_n    = redirect_pc;
            end else begin
                state_n = FAULT;
                fpc_n   = redirect_pc;
            end
        end else begin
            pop = out_valid && out_ready;
            if (state == RUN && (count != CW'(DEPTH) || pop)) begin
                push = 1'b1;
                pc_n = pc_inc;
                if ({1'b0, pc_inc} >= LIMIT) begin
                    state_n = FAULT;
                    fpc_n   = pc_inc;
                end
            end
        end
        kept    = count - CW'(pop);
        count_n = flush ? '0 : kept + CW'(push);
        rptr_n  = flush ? '0 : rptr + PW'(pop);
        wptr_n  = flush ? '0 : wptr + PW'(push);
        // Next head is the word being pushed only when nothing older remains
        if (kept != '0) begin
            head_instr = mem_instr[rptr_n];
            head_pc    = mem_pc[rptr_n];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            fault_pc  <= '0;
            count     <= '0;
            rptr      <= '0;
            wptr      <= '0;
            out_instr <= '0;
            out_pc    <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            fault_pc <= fpc_n;
            count    <= count_n;
            rptr     <= rptr_n;
            wptr     <= wptr_n;
            if (count_n != '0) begin
                out_instr <= head_instr;
                out_pc    <= head_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wptr] <= imem_rdata;
            mem_pc[wptr]    <= pc;
        end
    end

endmodule
